row_window_gen: RTL

- Vertical window former that sits directly upstream of the 3x3 kernel datapath in the image pipeline.
- Accepts a raster-order pixel stream, PIXELS_PER_BEAT pixels per beat, frame of IMAGE_DIM x IMAGE_DIM.
- Keeps the two previous rows in internal row stores and emits, per beat, a 3-row vertical stack: row r-2, row r-1 and row r at the same column.
- Owns all row-store read/write sequencing, so downstream stages see only a single AXI-Stream-style interface.

---
 rtl/row_window_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/row_window_gen.sv
// Vertical 3-row window former: keeps rows r-1 and r-2 in row stores and emits
// {row r-2, row r-1, row r} per beat through a single registered output stage.
module row_window_gen #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic [DATA_WIDTH-1:0]        s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic                         s_tlast,
  output logic [3*DATA_WIDTH-1:0]      m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast,
  output logic                         m_tuser,
  output logic [$clog2(IMAGE_DIM)-1:0] row_idx,
  output logic                         tlast_err
);

  localparam int BEATS = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = $clog2(IMAGE_DIM);

  // Handshake: a beat transfers on any rising clk edge where valid and ready
  // are both high; a producer holding valid keeps its payload stable until then.

  logic [DATA_WIDTH-1:0]   rs1_q [BEATS];
  logic [DATA_WIDTH-1:0]   rs2_q [BEATS];

  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [3*DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    m_tuser_q, m_tuser_d;
  logic [RW-1:0]           row_idx_q, row_idx_d;
  logic                    tlast_err_q, tlast_err_d;

  logic                    acc;
  logic                    emit;
  logic                    col_last;
  logic                    row_last;
  logic [DATA_WIDTH-1:0]   rs1_rd;
  logic [DATA_WIDTH-1:0]   rs2_rd;

  // Single output register, no skid: input may only advance when the output slot frees.
  assign s_tready = ~m_tvalid_q | m_tready;
  assign acc      = s_tvalid & s_tready;
  assign col_last = (col_q == CW'(BEATS - 1));
  assign row_last = (row_q == RW'(IMAGE_DIM - 1));
  assign emit     = acc & (row_q >= RW'(2));
  assign rs1_rd   = rs1_q[col_q];
  assign rs2_rd   = rs2_q[col_q];

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;
    m_tuser_d   = m_tuser_q;
    row_idx_d   = row_idx_q;
    tlast_err_d = tlast_err_q;

    if (acc) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) begin
        row_d = row_last ? '0 : row_q + RW'(1);
      end
      // s_tlast is only audited; the internal column count stays authoritative.
      if (s_tlast != col_last) begin
        tlast_err_d = 1'b1;
      end
    end

    if (emit) begin
      m_tdata_d  = {rs2_rd, rs1_rd, s_tdata};
      m_tvalid_d = 1'b1;
      m_tlast_d  = col_last;
      m_tuser_d  = col_last & row_last;
      row_idx_d  = row_q;
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      col_q       <= '0;
      row_q       <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tuser_q   <= 1'b0;
      row_idx_q   <= '0;
      tlast_err_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tuser_q   <= m_tuser_d;
      row_idx_q   <= row_idx_d;
      tlast_err_q <= tlast_err_d;
    end
  end

  // Row stores carry no reset; each frame's fill rows overwrite stale contents.
  always_ff @(posedge clk) begin
    if (acc) begin
      rs2_q[col_q] <= rs1_rd;
      rs1_q[col_q] <= s_tdata;
    end
  end

  assign m_tdata   = m_tdata_q;
  assign m_tvalid  = m_tvalid_q;
  assign m_tlast   = m_tlast_q;
  assign m_tuser   = m_tuser_q;
  assign row_idx   = row_idx_q;
  assign tlast_err = tlast_err_q;

endmodule
